// File: rtl/s_axis_pkt_buffer.sv
// s_axis_pkt_buffer: ring of AXI-Stream packet slots with registered random byte reads of the head packet (S_AXIS_PKT_BUF_DROP_EN drops overflowed packets instead of truncating)
module s_axis_pkt_buffer #(
  parameter int DATA_BYTES = 4,
  parameter int SLOT_BYTES = 1024,
  parameter int NUM_SLOTS = 2,
  parameter int READ_BYTES = 4,
  localparam int LEN_W = $clog2(SLOT_BYTES) + 1,
  localparam int CNT_W = $clog2(NUM_SLOTS + 1)
)(
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
  input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic [LEN_W-1:0]        read_ptr,
  output logic [8*READ_BYTES-1:0] rd_data,
  output logic                    pkt_valid,
  output logic [LEN_W-1:0]        pkt_len,
  output logic                    pkt_trunc,
  input  logic                    pkt_release,
  output logic [CNT_W-1:0]        slots_used,
  output logic [15:0]             drop_count
);
  localparam int AW = $clog2(SLOT_BYTES);
  localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
`ifdef S_AXIS_PKT_BUF_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [NUM_SLOTS][SLOT_BYTES];
  logic [LEN_W-1:0] slot_len [NUM_SLOTS];
  logic slot_trunc [NUM_SLOTS];
  logic [SW-1:0] head, tail;
  logic [LEN_W-1:0] wr_len, cur_len, add, new_len;
  logic [8*READ_BYTES-1:0] rd_next;
  logic take, ovf, close, commit, drop, release_ok;

  // a packet in flight always continues at wr_len; a fresh one starts at byte 0
  assign cur_len = state == IDLE ? '0 : wr_len;
  assign ovf = cur_len == LEN_W'(SLOT_BYTES);
  assign new_len = ovf ? cur_len : cur_len + add;
  assign close = s_axis_tlast || s_axis_tkeep != '1 || ovf;
  assign take = s_axis_tvalid && s_axis_tready && state != DISCARD;
  assign commit = take && close && new_len != '0 && !(ovf && DROP);
  assign drop = take && ovf && DROP;
  assign release_ok = pkt_release && pkt_valid;
  assign pkt_valid = slots_used != '0;
  assign pkt_len = pkt_valid ? slot_len[head] : '0;
  assign pkt_trunc = !DROP && pkt_valid && slot_trunc[head];

  // byte count of the current beat
  always_comb begin
    add = '0;
    for (int b = 0; b < DATA_BYTES; b++) add = add + LEN_W'(s_axis_tkeep[b]);
  end

  // write FSM next state and ready; a close without tlast swallows the rest of the packet
  always_comb begin
    state_nxt = state;
    s_axis_tready = aresetn && (state != IDLE || slots_used < CNT_W'(NUM_SLOTS));
    if (s_axis_tvalid && s_axis_tready)
      state_nxt = state == DISCARD ? (s_axis_tlast ? IDLE : DISCARD)
                : close ? (s_axis_tlast ? IDLE : DISCARD) : WRITE;
  end

  // FSM state, ring pointers, occupancy and drop counter
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      wr_len <= '0;
      slots_used <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (take) wr_len <= new_len;
      if (commit) tail <= tail == SW'(NUM_SLOTS - 1) ? '0 : tail + 1'b1;
      if (release_ok) head <= head == SW'(NUM_SLOTS - 1) ? '0 : head + 1'b1;
      slots_used <= slots_used + CNT_W'(commit) - CNT_W'(release_ok);
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

  // per-slot length and truncation flag, written when the tail slot commits
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slot_len[s] <= '0;
        slot_trunc[s] <= 1'b0;
      end
    end else if (commit) begin
      slot_len[tail] <= new_len;
      slot_trunc[tail] <= ovf;
    end
  end

  // packet storage; contents need no reset since length gates every read
  always_ff @(posedge aclk) begin
    if (take && !ovf)
      for (int b = 0; b < DATA_BYTES; b++)
        if (s_axis_tkeep[b]) mem[tail][cur_len[AW-1:0] + AW'(b)] <= s_axis_tdata[8*b +: 8];
  end

  // read window: byte i of the head packet lands MSB-first, past-the-end bytes read as zero
  for (genvar i = 0; i < READ_BYTES; i++) begin : g_rd
    logic [LEN_W:0] p;
    assign p = {1'b0, read_ptr} + (LEN_W + 1)'(i);
    assign rd_next[8*(READ_BYTES-1-i) +: 8] = p < {1'b0, pkt_len} ? mem[head][p[AW-1:0]] : 8'h00;
  end

  // registered read data
  always_ff @(posedge aclk) begin
    rd_data <= aresetn ? rd_next : '0;
  end
endmodule

// File: doc/s_axis_pkt_buffer.md
# s_axis_pkt_buffer

Multi-slot AXI-Stream packet buffer, parametrised in bus width, slot size and slot count. Captures whole packets from the network-side AXI stream into a ring of packet slots. Gives the router's header parser and forwarding logic registered, byte-addressed random reads of the oldest complete packet. A new packet is written while an older one is still being parsed, and a slot is freed by an explicit release rather than a global flush.

## Interface
- `DATA_BYTES`, 4, stream bus width in bytes (power of two, ≥1)
- `SLOT_BYTES`, 1024, capacity of one slot in bytes (multiple of DATA_BYTES)
- `NUM_SLOTS`, 2, number of packet slots (≥1)
- `READ_BYTES`, 4, width of the random-read window in bytes
- Derived: `LEN_W` = $clog2(SLOT_BYTES)+1; `CNT_W` = $clog2(NUM_SLOTS+1)

- `aclk`  in  1  clock, all logic on rising edge
- `aresetn`  in  1  reset, synchronous, active-low
- `s_axis_tdata`  in  8*DATA_BYTES  stream data; byte 0 = [7:0] = first byte on the wire
- `s_axis_tkeep`  in  DATA_BYTES  byte enables, low-aligned contiguous masks only
- `s_axis_tvalid`  in  1  beat valid
- `s_axis_tlast`  in  1  last beat of packet
- `s_axis_tready`  out  1  beat accepted when tvalid && tready
- `read_ptr`  in  LEN_W  byte offset into head packet
- `rd_data`  out  8*READ_BYTES  head-packet bytes [read_ptr .. read_ptr+READ_BYTES-1], first byte in MSBs
- `pkt_valid`  out  1  at least one committed packet
- `pkt_len`  out  LEN_W  byte length of head packet
- `pkt_trunc`  out  1  head packet was truncated on overflow
- `pkt_release`  in  1  free head slot (single-cycle pulse)
- `slots_used`  out  CNT_W  committed slots
- `drop_count`  out  16  packets dropped, saturating

## Operation
- Write FSM has three states: IDLE, WRITE, DISCARD.
- IDLE: tready = (slots_used < NUM_SLOTS). The first accepted beat reserves the tail slot and moves to WRITE; if that beat also closes the packet, it commits immediately and the FSM stays in IDLE.
- WRITE: tready = 1. Each beat is stored at word wr_len/DATA_BYTES of the slot, and wr_len += popcount(tkeep).
- Packet close: a beat with tlast = 1, or with tkeep ≠ all-ones, closes the packet.
  - The slot is committed: pkt_len = wr_len, trunc flag stored, tail advances modulo NUM_SLOTS.
  - A partial-keep close without tlast goes to DISCARD.
- Zero-length close (first beat tkeep = 0): slot is not committed and stays free.
- Overflow: a beat accepted while wr_len == SLOT_BYTES has its bytes dropped. Handling depends on the Configuration macro. A tlast beat that lands exactly at SLOT_BYTES is not an overflow.
- DISCARD: tready = 1. Beats are ignored until an accepted tlast, then the FSM returns to IDLE.
- Read path:
  - Head slot holds the oldest committed packet.
  - Byte i of rd_data (MSB-first) = packet byte read_ptr+i if read_ptr+i < pkt_len, else 8'h00.
  - Any read_ptr alignment is allowed; the window spans slot words as needed.
- Release: pkt_release && pkt_valid advances head and decrements slots_used. Release while !pkt_valid is ignored.
- Commit and release in the same cycle leave slots_used unchanged. A packet of exactly SLOT_BYTES is legal and fills the slot.

## Timing
- rd_data is registered: it reflects read_ptr and the head slot sampled at the previous rising edge (1-cycle latency).
- pkt_valid, pkt_len, pkt_trunc and slots_used update on the edge after the commit or release.
- tready is combinational from state and slots_used; it has no dependence on tvalid.
- A packet can begin on the cycle after the previous packet's last beat.
- Reset (aresetn = 0 at an edge), taken mid-packet or otherwise, produces:
  - tready = 0 while aresetn = 0; state = IDLE.
  - All slots freed, head = tail = 0, slots_used = 0.
  - pkt_valid = 0, pkt_len = 0, pkt_trunc = 0, rd_data = 0, drop_count = 0.
  - Any partial packet is lost.

## Configuration
- `S_AXIS_PKT_BUF_DROP_EN` undefined:
  - An overflowed packet is committed truncated, with pkt_len = SLOT_BYTES and pkt_trunc = 1.
  - If the overflowing beat is not tlast, the FSM goes to DISCARD.
  - drop_count stays 0.
- `S_AXIS_PKT_BUF_DROP_EN` defined:
  - The overflowed packet is abandoned (not committed, slot stays free) and drop_count increments, saturating at 16'hFFFF.
  - If the overflowing beat is not tlast, the FSM goes to DISCARD.
  - pkt_trunc is tied to 0.

## Test plan
- Single-packet write and read:
  - Stimulus (defaults): 3 beats 0x44332211, 0x88776655, 0x0000AA99 with tkeep=4'b0011 and tlast.
  - Required: pkt_valid = 1, pkt_len = 10.
  - read_ptr = 0 → rd_data = 0x11223344 one cycle later.
  - read_ptr = 7 → rd_data = 0x8899AA00.
- Slot exhaustion:
  - Stimulus: NUM_SLOTS = 2, write two packets, no release.
  - Required: tready = 0 and slots_used = 2.
  - A single pkt_release → tready = 1 on the next cycle, and pkt_len = length of packet 2.
- Overflow:
  - Stimulus: SLOT_BYTES = 16, a 6-beat full-keep packet.
  - Without the macro: committed with pkt_len = 16, pkt_trunc = 1, and all 6 beats accepted.
  - With the macro: pkt_valid stays 0 and drop_count = 1.
- Partial keep without tlast:
  - Stimulus: tkeep = 4'b0111 on beat 2, then 2 more beats ending in tlast.
  - Required: pkt_len = 7, and the following beats are discarded with tready = 1.
- Simultaneous commit and release:
  - Stimulus: last beat of packet 2 accepted in the same cycle as the release of packet 1.
  - Required: slots_used stays 1, and the head becomes packet 2.
- Reset mid-packet:
  - Stimulus: aresetn = 0 for 1 cycle during beat 2.
  - Required: slots_used = 0, pkt_valid = 0, rd_data = 0.
  - The next packet is written to slot 0 and reads back correctly.
